// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and baud divisor helper shared by uart_rx and uart_tx
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_sync.sv
// uart_sync: N-flop synchroniser, resets to 1 (idle line level)
module uart_sync #(
  parameter int N = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic [N-1:0] q;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) q <= '1;
    else q <= {q[N-2:0], i_d};
  assign o_q = q[N-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with valid/ready output and framing/overrun pulses
// Define UART_RX_PARITY_EN to add an even-parity bit and o_parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD = 9600
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_parity_err
`endif
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW = $clog2(CPB) + 1;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic rx_s, rx_prev, zero, done, ferr;
`ifdef UART_RX_PARITY_EN
  logic par, par_n, perr;
`endif
  uart_sync #(.N(2)) u_sync (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_rx), .o_q(rx_s));
  assign zero = cnt == '0;
  always_comb begin
    state_n = state;
    cnt_n = (state == IDLE) ? cnt : cnt - CW'(1);
    idx_n = idx;
    shift_n = shift;
    done = 1'b0;
    ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n = par;
    perr = 1'b0;
`endif
    case (state)
      IDLE: if (rx_prev && !rx_s) begin
        cnt_n = CW'(CPB / 2 - 1);
        state_n = START;
      end
      START: if (zero) begin
        state_n = rx_s ? IDLE : DATA;
        cnt_n = CW'(CPB - 1);
        idx_n = '0;
      end
      DATA: if (zero) begin
        shift_n = {rx_s, shift[7:1]};
        cnt_n = CW'(CPB - 1);
        idx_n = (idx == 3'd7) ? idx : idx + 3'd1;
`ifdef UART_RX_PARITY_EN
        state_n = (idx == 3'd7) ? PARITY : DATA;
`else
        state_n = (idx == 3'd7) ? STOP : DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (zero) begin
        par_n = rx_s;
        cnt_n = CW'(CPB - 1);
        state_n = STOP;
      end
`endif
      STOP: if (zero) begin
        state_n = IDLE;
        ferr = !rx_s;
`ifdef UART_RX_PARITY_EN
        done = rx_s && (par == ^shift);
        perr = rx_s && (par != ^shift);
`else
        done = rx_s;
`endif
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      rx_prev <= 1'b1;
      o_data <= '0;
      o_valid <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      rx_prev <= rx_s;
      o_frame_err <= ferr;
      o_overrun <= done && o_valid && !i_ready;
`ifdef UART_RX_PARITY_EN
      par <= par_n;
      o_parity_err <= perr;
`endif
      // a completion coinciding with a handshake replaces the consumed byte
      if (done && (!o_valid || i_ready)) begin
        o_data <= shift;
        o_valid <= 1'b1;
      end else if (i_ready) o_valid <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;
  logic clk = 0, rst = 1, rx = 1, ready = 0;
  logic [7:0] data;
  logic valid, ferr, ovr, perr;
  int checks = 0, errors = 0;
  int fe_n = 0, ov_n = 0, pe_n = 0, fe_exp = 0, ov_exp = 0, pe_exp = 0;
  bit wide = 0, both = 0;
  logic pf = 0, po = 0, pp = 0;
  logic [7:0] got_q[$], exp_q[$];

  uart_rx #(.CLK_FREQ(1000000), .BAUD(100000)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx(rx), .o_data(data), .o_valid(valid),
    .i_ready(ready), .o_frame_err(ferr), .o_overrun(ovr)
`ifdef UART_RX_PARITY_EN
    , .o_parity_err(perr)
`endif
  );
`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid && ready) got_q.push_back(data);
    if (ferr) fe_n++;
    if (ovr) ov_n++;
    if (perr) pe_n++;
    if ((ferr && pf) || (ovr && po) || (perr && pp)) wide = 1;
    if (int'(ferr) + int'(ovr) + int'(perr) > 1) both = 1;
    pf = ferr; po = ovr; pp = perr;
  end

  // frame-level reference: what a receiver must report for one whole frame
  task automatic model_frame(input logic [7:0] b, input bit stop, input bit par_ok, input bit held);
    if (!stop) fe_exp++;
    else if (!par_ok) pe_exp++;
    else if (held) ov_exp++;
    else exp_q.push_back(b);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input bit par_ok);
    rx = 0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ !par_ok;
    repeat (10) @(negedge clk);
`endif
    rx = stop;
    repeat (10) @(negedge clk);
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, got_q[i], exp_q[i]);
    check({tag, "_frame_err"}, fe_n, fe_exp);
    check({tag, "_overrun"}, ov_n, ov_exp);
    check({tag, "_parity_err"}, pe_n, pe_exp);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_flags", {ferr, ovr, perr}, 0);
    rst = 0;
    ready = 1;
    repeat (5) @(negedge clk);

    model_frame(8'h61, 1, 1, 0);
    fork send_frame(8'h61, 1, 1); join_none
    n = 0;
    while (!valid && n < 150) begin
      @(negedge clk);
      n++;
    end
    check("lat_0x61", (n >= 95 && n <= 101), 1);
    check("data_0x61", data, 8'h61);
    @(negedge clk);
    check("pulse_0x61", valid, 0);
    wait fork;
    repeat (5) @(negedge clk);
    compare("single");

    ready = 0;
    model_frame(8'h41, 1, 1, 0);
    model_frame(8'h7A, 1, 1, 1);
    send_frame(8'h41, 1, 1);
    send_frame(8'h7A, 1, 1);
    repeat (3) @(negedge clk);
    check("ovr_data_held", data, 8'h41);
    check("ovr_valid_held", valid, 1);
    ready = 1;
    @(negedge clk);
    check("ovr_valid_drop", valid, 0);
    check("ovr_data_not_new", data, 8'h41);
    compare("overrun");

    model_frame(8'h55, 0, 1, 0);
    send_frame(8'h55, 0, 1);
    repeat (30) @(negedge clk);
    check("break_valid", valid, 0);
    rx = 1;
    repeat (20) @(negedge clk);
    compare("framing");

    rx = 0;
    repeat (3) @(negedge clk);
    rx = 1;
    repeat (20) @(negedge clk);
    compare("glitch");
    model_frame(8'h33, 1, 1, 0);
    send_frame(8'h33, 1, 1);
    repeat (5) @(negedge clk);
    compare("after_glitch");

    rx = 0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'hC3 >> i);
      repeat (10) @(negedge clk);
    end
    rx = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    rx = 1;
    repeat (2) @(negedge clk);
    check("midrst_data", data, 0);
    check("midrst_valid", valid, 0);
    rst = 0;
    repeat (20) @(negedge clk);
    model_frame(8'h5A, 1, 1, 0);
    send_frame(8'h5A, 1, 1);
    repeat (5) @(negedge clk);
    compare("after_reset");

`ifdef UART_RX_PARITY_EN
    model_frame(8'h07, 1, 0, 0);
    send_frame(8'h07, 1, 0);
    model_frame(8'h07, 1, 1, 0);
    send_frame(8'h07, 1, 1);
    repeat (5) @(negedge clk);
    compare("parity");
`endif

    for (int k = 0; k < 24; k++) begin
      logic [7:0] b;
      bit stop, par_ok;
      b = 8'($urandom);
      stop = $urandom_range(0, 4) != 0;
`ifdef UART_RX_PARITY_EN
      par_ok = $urandom_range(0, 3) != 0;
`else
      par_ok = 1;
`endif
      model_frame(b, stop, par_ok, 0);
      send_frame(b, stop, par_ok);
      rx = 1;
      repeat ($urandom_range(2, 12)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    compare("random");

    check("pulse_width", wide, 0);
    check("flag_overlap", both, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
